// File: rtl/uart_rx_buf.sv
// uart_rx_buf: buffered 8N1 UART receiver with a first-word fall-through FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose uart_rx_parity_err_o.
module uart_rx_buf #(
    parameter int unsigned FIFO_AW     = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               uart_rx_i,
    input  logic [31:0]        uart_rx_baud_div_i,
    input  logic               uart_rx_data_rdy_i,
    output logic               uart_rx_data_vld_o,
    output logic [7:0]         uart_rx_data_o,
    output logic               uart_rx_frame_err_o,
    output logic               uart_rx_ovf_o,
`ifdef UART_RX_PARITY_EN
    output logic               uart_rx_parity_err_o,
`endif
    output logic [FIFO_AW:0]   uart_rx_fifo_cnt_o
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    // Input synchroniser and edge detect
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   w_rx_s;
    logic                   w_fall;

    // Receive FSM state
    state_e      r_state, w_state_d;
    logic [31:0] r_cnt, w_cnt_d;
    logic [31:0] r_div, w_div_d;
    logic [2:0]  r_idx, w_idx_d;
    logic [7:0]  r_shift, w_shift_d;
    logic [31:0] w_div_eff;
    logic        w_cnt_zero;
    logic        w_push;
    logic        w_frame_err;
`ifdef UART_RX_PARITY_EN
    logic        r_par, w_par_d;
    logic        w_parity_err;
    logic        r_parity_err;
`endif

    // FIFO state
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr, w_rptr_d;
    logic [FIFO_AW:0]   r_count, w_count_d;
    logic [7:0]         r_data, w_data_d;
    logic               w_full, w_pop, w_wr, w_ovf;
    logic               r_frame_err, r_ovf;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_fall     = !w_rx_s && r_rx_prev;
    assign w_div_eff  = (uart_rx_baud_div_i < 32'd2) ? 32'd2 : uart_rx_baud_div_i;
    assign w_cnt_zero = (r_cnt == 32'd0);

    // Synchroniser chain; idles high so reset cannot fake a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], uart_rx_i};
            r_rx_prev <= w_rx_s;
        end
    end

    // Receive FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_div   <= 32'd2;
            r_idx   <= '0;
            r_shift <= '0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_div   <= w_div_d;
            r_idx   <= w_idx_d;
            r_shift <= w_shift_d;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_d;
`endif
        end
    end

    // Receive FSM next-state: sample each bit when the down-counter hits zero
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_div_d     = r_div;
        w_idx_d     = r_idx;
        w_shift_d   = r_shift;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_d      = r_par;
        w_parity_err = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_fall) begin
                    w_div_d   = w_div_eff;
                    w_cnt_d   = (w_div_eff >> 1) - 32'd1;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_cnt_zero) begin
                    if (w_rx_s) begin
                        w_state_d = StIdle;  // glitch, not a real start bit
                    end else begin
                        w_cnt_d   = r_div - 32'd1;
                        w_idx_d   = '0;
                        w_state_d = StData;
                    end
                end else begin
                    w_cnt_d = r_cnt - 32'd1;
                end
            end
            StData: begin
                if (w_cnt_zero) begin
                    w_shift_d = {w_rx_s, r_shift[7:1]};
                    w_cnt_d   = r_div - 32'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_d = StParity;
`else
                        w_state_d = StStop;
`endif
                    end else begin
                        w_idx_d = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt - 32'd1;
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (w_cnt_zero) begin
                    w_par_d   = w_rx_s;
                    w_cnt_d   = r_div - 32'd1;
                    w_state_d = StStop;
                end else begin
                    w_cnt_d = r_cnt - 32'd1;
                end
`else
                w_state_d = StIdle;
`endif
            end
            StStop: begin
                if (w_cnt_zero) begin
`ifdef UART_RX_PARITY_EN
                    w_parity_err = (^r_shift) != r_par;
`endif
                    if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_push = !w_parity_err;
`else
                        w_push = 1'b1;
`endif
                        w_state_d = StIdle;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_d   = StBreak;
                    end
                end else begin
                    w_cnt_d = r_cnt - 32'd1;
                end
            end
            StBreak: begin
                // A held-low line yields a single error; wait for it to return high.
                if (w_rx_s) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = (r_count != '0) && uart_rx_data_rdy_i;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovf     = w_push && w_full && !w_pop;
    assign w_rptr_d  = r_rptr + FIFO_AW'(w_pop);
    assign w_count_d = r_count + (FIFO_AW + 1)'(w_wr) - (FIFO_AW + 1)'(w_pop);

    // Next registered head: the incoming byte only when the FIFO is otherwise empty
    always_comb begin
        w_data_d = r_data;
        if (w_wr && (w_count_d == (FIFO_AW + 1)'(1))) begin
            w_data_d = r_shift;
        end else if (w_count_d != '0) begin
            w_data_d = r_mem[w_rptr_d];
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy, registered head and status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_data       <= '0;
            r_frame_err  <= 1'b0;
            r_ovf        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_wptr       <= r_wptr + FIFO_AW'(w_wr);
            r_rptr       <= w_rptr_d;
            r_count      <= w_count_d;
            r_data       <= w_data_d;
            r_frame_err  <= w_frame_err;
            r_ovf        <= w_ovf;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_parity_err;
`endif
        end
    end

    assign uart_rx_data_vld_o  = (r_count != '0);
    assign uart_rx_data_o      = r_data;
    assign uart_rx_frame_err_o = r_frame_err;
    assign uart_rx_ovf_o       = r_ovf;
    assign uart_rx_fifo_cnt_o  = r_count;
`ifdef UART_RX_PARITY_EN
    assign uart_rx_parity_err_o = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: scoreboard of expected bytes popped on vld & rdy.
module tb_uart_rx_buf;

    localparam int BAUD    = 100;
    localparam int FIFO_AW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx;
    logic [31:0]      baud;
    logic             rdy;
    logic             vld;
    logic [7:0]       data;
    logic             ferr;
    logic             ovf;
    logic [FIFO_AW:0] fifo_cnt;
`ifdef UART_RX_PARITY_EN
    logic             perr;
`endif

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    int ferr_cnt = 0;
    int ovf_cnt  = 0;
    int pop_s, ferr_s, ovf_s;
    logic [FIFO_AW:0] cnt_snap;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_buf #(
        .FIFO_AW     (FIFO_AW),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .uart_rx_i           (rx),
        .uart_rx_baud_div_i  (baud),
        .uart_rx_data_rdy_i  (rdy),
        .uart_rx_data_vld_o  (vld),
        .uart_rx_data_o      (data),
        .uart_rx_frame_err_o (ferr),
        .uart_rx_ovf_o       (ovf),
`ifdef UART_RX_PARITY_EN
        .uart_rx_parity_err_o(perr),
`endif
        .uart_rx_fifo_cnt_o  (fifo_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Monitor: sample 2 ns after the falling edge, well away from the rising edge
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (vld && rdy) begin
                pop_cnt++;
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (ferr) ferr_cnt++;
            if (ovf) ovf_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame; optionally hold the line low after a low stop bit,
    // and pulse rdy for one cycle at frame cycle rdy_at (-1 = never).
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int hold_low,
                              input int rdy_at);
        int b;
        for (int c = 0; c < 10 * BAUD; c++) begin
            @(negedge clk);
            b = c / BAUD;
            if (b == 0) rx = 1'b0;
            else if (b <= 8) rx = d[b-1];
            else rx = stop_val;
            if (rdy_at >= 0) begin
                if (c == rdy_at) rdy = 1'b1;
                if (c == rdy_at + 1) begin
                    rdy      = 1'b0;
                    cnt_snap = fifo_cnt;
                end
            end
        end
        if (stop_val == 1'b0) begin
            repeat (hold_low) @(negedge clk);
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        rdy = 1'b1;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
        idle(5);
    endtask

    task automatic snap();
        pop_s  = pop_cnt;
        ferr_s = ferr_cnt;
        ovf_s  = ovf_cnt;
    endtask

    initial begin
        rst  = 1'b1;
        rx   = 1'b1;
        rdy  = 1'b0;
        baud = BAUD;
        cnt_snap = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", 32'({vld, data, ferr, ovf, fifo_cnt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(20);

        // Three back-to-back bytes with the consumer ready
        snap();
        rdy = 1'b1;
        for (int v = 8'h61; v <= 8'h63; v++) begin
            exp_q.push_back(8'(v));
            send_frame(8'(v), 1'b1, 0, -1);
        end
        idle(150);
        check_eq("t1_sb_empty", exp_q.size(), 0);
        check_eq("t1_pops", pop_cnt - pop_s, 3);
        check_eq("t1_ferr", ferr_cnt - ferr_s, 0);
        check_eq("t1_ovf", ovf_cnt - ovf_s, 0);

        // Nine bytes into an 8-deep FIFO with no consumer
        snap();
        rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 0, -1);
        end
        idle(60);
        check_eq("t2_cnt_full", fifo_cnt, 8);
        check_eq("t2_ovf_once", ovf_cnt - ovf_s, 1);
        check_eq("t2_no_pop", pop_cnt - pop_s, 0);
        drain("t2_drain", 200);
        check_eq("t2_cnt_empty", fifo_cnt, 0);
        check_eq("t2_pops", pop_cnt - pop_s, 8);

        // Short low glitch on an idle line
        snap();
        @(negedge clk);
        rx = 1'b0;
        idle(30);
        rx = 1'b1;
        idle(200);
        check_eq("t3_no_vld", pop_cnt - pop_s, 0);
        check_eq("t3_no_ferr", ferr_cnt - ferr_s, 0);
        check_eq("t3_cnt", fifo_cnt, 0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 0, -1);
        idle(150);
        check_eq("t3_a5", pop_cnt - pop_s, 1);

        // Framing error followed by a long break
        snap();
        send_frame(8'h3C, 1'b0, 500, -1);
        idle(50);
        check_eq("t4_ferr_once", ferr_cnt - ferr_s, 1);
        check_eq("t4_no_vld", pop_cnt - pop_s, 0);
        check_eq("t4_cnt", fifo_cnt, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 0, -1);
        idle(150);
        check_eq("t4_5a", pop_cnt - pop_s, 1);
        check_eq("t4_ferr_after", ferr_cnt - ferr_s, 1);

        // Push and pop in the same cycle while full: push lands at cycle 952
        // (edge seen 2 cycles late, first sample 50 later, stop 900 after that)
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            send_frame(8'(8'h10 + i), 1'b1, 0, -1);
        end
        idle(20);
        check_eq("t5_cnt_full", fifo_cnt, 8);
        snap();
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, 0, 10 * BAUD - BAUD / 2 + 2);
        idle(60);
        check_eq("t5_no_ovf", ovf_cnt - ovf_s, 0);
        check_eq("t5_cnt_snap", cnt_snap, 8);
        check_eq("t5_cnt_after", fifo_cnt, 8);
        check_eq("t5_one_pop", pop_cnt - pop_s, 1);
        drain("t5_drain", 200);
        check_eq("t5_cnt_empty", fifo_cnt, 0);

        // Reset with one byte buffered and a frame in progress
        rdy = 1'b0;
        send_frame(8'h77, 1'b1, 0, -1);
        idle(20);
        check_eq("t6_buffered", fifo_cnt, 1);
        for (int c = 0; c < 450; c++) begin
            @(negedge clk);
            rx = (c < BAUD) ? 1'b0 : 1'b1;
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            check_eq("t6_rst_outs", 32'({vld, data, ferr, ovf, fifo_cnt}), 32'd0);
        end
        rst = 1'b0;
        snap();
        idle(700);
        rdy = 1'b1;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 0, -1);
        idle(150);
        check_eq("t6_sb_empty", exp_q.size(), 0);
        check_eq("t6_only_12", pop_cnt - pop_s, 1);
        check_eq("t6_no_ferr", ferr_cnt - ferr_s, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_buf.md
Name: uart_rx_buf

Overview:
- Buffered UART receiver: the far end of a uart_tx link.
- Deserialises 8N1 frames (optionally 8E1) from an asynchronous serial line, checks framing, and queues bytes in a small FIFO.
- Presents bytes on a valid/ready interface to a CPU/bus bridge.
- Reports framing errors and FIFO overflow as single-cycle pulses.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries
SYNC_STAGES, 2, input synchroniser flops on uart_rx_i (minimum 2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
uart_rx_i  input  1  serial line, idle high, asynchronous to clk_i
uart_rx_baud_div_i  input  32  clock cycles per bit
uart_rx_data_rdy_i  input  1  consumer ready
uart_rx_data_vld_o  output  1  FIFO not empty
uart_rx_data_o  output  8  FIFO head byte
uart_rx_frame_err_o  output  1  one-cycle pulse: stop bit sampled low
uart_rx_ovf_o  output  1  one-cycle pulse: byte dropped, FIFO full
uart_rx_fifo_cnt_o  output  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (rst_i high at posedge clk_i):
  - State goes to IDLE; FIFO is emptied.
  - All outputs go to 0. Synchroniser flops load 1.
  - Reset mid-frame abandons the partial byte.
- Input path:
  - uart_rx_i passes through SYNC_STAGES flops. All logic uses the synchronised value rx_s.
  - Falling edge is detected as rx_s==0 with the previous rx_s==1.
- Baud divisor:
  - Latched into div_q on start-edge detection. Changes mid-frame take effect on the next frame.
  - Values below 2 are treated as 2.
- Bit counter cnt counts down. Sample points:
  - first sample at floor(div_q/2) cycles after the edge;
  - then every div_q cycles.
- FSM states and transitions:
  - IDLE: on falling edge, latch div_q, load cnt = div_q/2 - 1, go to START.
  - START: at cnt==0, sample rx_s.
    - 1 (glitch): return to IDLE, no error.
    - 0: load cnt = div_q - 1, bit index = 0, go to DATA.
  - DATA: at each cnt==0, shift rx_s into the shift register, LSB first. After bit 7, go to STOP (or PARITY when enabled).
  - STOP: at cnt==0, sample rx_s.
    - 1: push the byte, go to IDLE.
    - 0: pulse uart_rx_frame_err_o, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line yields exactly one error.
- Push timing:
  - A byte written in cycle N appears with uart_rx_data_vld_o high in cycle N+1.
  - uart_rx_data_o is registered FIFO head (first-word fall-through).
- FIFO:
  - Pop occurs when vld_o & rdy_i.
  - Push when full and no pop in the same cycle: byte dropped, uart_rx_ovf_o pulses, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the byte is not bypassed; it appears the next cycle.
  - Read and write pointers wrap modulo 2**FIFO_AW. uart_rx_fifo_cnt_o ranges 0..2**FIFO_AW.
- uart_rx_data_o holds its last value when vld_o is low. Its content is don't-care in that case.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit.
  - Port uart_rx_parity_err_o (output, 1) pulses one cycle on mismatch, in the STOP-sample cycle.
  - A byte with a parity error is discarded. A byte with both parity and framing errors pulses both outputs.
- Undefined:
  - No PARITY state and no uart_rx_parity_err_o port; 8N1 frames only.

Test Plan:
- baud_div=100, rdy=1, uart_tx sends 0x61, 0x62, 0x63 back-to-back → three vld pulses with data 0x61, 0x62, 0x63 in order; no error pulses.
- baud_div=100, rdy=0, send 9 bytes 0x00..0x08 with FIFO_AW=3 → cnt saturates at 8; ovf pulses once on 9th byte; draining yields 0x00..0x07.
- 30-cycle low glitch on idle line, baud_div=100 → returns to IDLE; no vld, no frame_err; next valid frame 0xA5 received correctly.
- Frame 0x3C with stop bit forced low, line held low 500 cycles then high → exactly one frame_err pulse; no vld; following frame 0x5A received.
- FIFO full (8 entries), rdy asserted in the same cycle a 9th byte 0x99 is pushed → no ovf; cnt stays 8; 0x99 is the last byte drained.
- rst_i asserted mid-DATA of frame 0xFF, released, then frame 0x12 sent → all outputs 0 during reset; only 0x12 is received.
